// File: rtl/crc_engine.sv
// Bit-serial CRC-W engine for the CAN path: MSB-first update, stuff-bit skipping, CRC field check/send.
// Optional macro CRC_TX_SEND_EN builds the SEND state and drives tx_bit; otherwise mode_tx is ignored.
module crc_engine #(
    parameter int           W        = 15,
    parameter logic [W-1:0] POLY     = 15'h4599,
    parameter logic [W-1:0] INIT_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic         enable,
    input  logic         bit_in,
    input  logic         stuff_bit,
    input  logic         finish,
    input  logic         mode_tx,
    output logic [W-1:0] crc,
    output logic         tx_bit,
    output logic         busy,
    output logic         done,
    output logic         crc_ok,
    output logic         crc_err,
    output logic [15:0]  bit_count
);

    localparam int IDX_W = 6;

`ifdef CRC_TX_SEND_EN
    typedef enum logic [2:0] {IDLE, CALC, CHECK, SEND, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, CALC, CHECK, DONE} state_t;
`endif

    state_t           state, state_n;
    logic [W-1:0]     ref_q;
    logic [W-1:0]     ref_sh;
    logic [W-1:0]     crc_shift;
    logic [IDX_W-1:0] idx;
    logic             mism;
    logic             qual;
    logic             ref_bit;
    logic             last_idx;
    logic             go_send;

    assign qual      = enable && !stuff_bit;
    assign crc_shift = {crc[W-2:0], 1'b0} ^ ((crc[W-1] ^ bit_in) ? POLY : '0);
    // Field bits are taken MSB first; shifting avoids a variable down-index.
    assign ref_sh    = ref_q << idx;
    assign ref_bit   = ref_sh[W-1];
    assign last_idx  = (idx == IDX_W'(W - 1));

`ifdef CRC_TX_SEND_EN
    assign go_send = mode_tx;
`else
    assign go_send = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (init) begin
            state_n = CALC;
        end else begin
            case (state)
                CALC:  if (finish) state_n = go_send ? state_t'(3) : CHECK;
                CHECK: if (qual && last_idx) state_n = DONE;
`ifdef CRC_TX_SEND_EN
                SEND:  if (qual && last_idx) state_n = DONE;
`endif
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc       <= INIT_VAL;
            bit_count <= '0;
            ref_q     <= '0;
            idx       <= '0;
            mism      <= 1'b0;
        end else if (init) begin
            crc       <= INIT_VAL;
            bit_count <= '0;
            idx       <= '0;
            mism      <= 1'b0;
        end else begin
            case (state)
                CALC: begin
                    if (qual) begin
                        crc <= crc_shift;
                        if (bit_count != 16'hFFFF) bit_count <= bit_count + 16'd1;
                    end
                    // A data bit arriving with finish is part of the snapshot.
                    if (finish) begin
                        ref_q <= qual ? crc_shift : crc;
                        idx   <= '0;
                        mism  <= 1'b0;
                    end
                end
                CHECK: begin
                    if (qual) begin
                        if (bit_in != ref_bit) mism <= 1'b1;
                        idx <= idx + 1'b1;
                    end
                end
`ifdef CRC_TX_SEND_EN
                SEND: begin
                    if (qual) idx <= idx + 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef CRC_TX_SEND_EN
    assign tx_bit = (state == SEND) ? ref_bit : 1'b0;
    assign busy   = (state == CALC) || (state == CHECK) || (state == SEND);
`else
    assign tx_bit = 1'b0;
    assign busy   = (state == CALC) || (state == CHECK);
`endif
    assign done    = (state == DONE);
    assign crc_ok  = done && !mism;
    assign crc_err = done && mism;

endmodule

// File: tb/tb_crc_engine.sv
// Directed bench for crc_engine: CRC-8/0x07 instance for state and check behaviour, CAN-15 instance for the reference string.
module tb_crc_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init = 1'b0, enable = 1'b0, bit_in = 1'b0, stuff_bit = 1'b0;
    logic finish = 1'b0, mode_tx = 1'b0;

    logic [7:0]  crc8;
    logic        tx8, busy8, done8, ok8, err8;
    logic [15:0] bc8;
    logic [14:0] crc15;
    logic        tx15, busy15, done15, ok15, err15;
    logic [15:0] bc15;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    crc_engine #(.W(8), .POLY(8'h07), .INIT_VAL(8'h00)) d8 (
        .clk(clk), .rst(rst), .init(init), .enable(enable), .bit_in(bit_in),
        .stuff_bit(stuff_bit), .finish(finish), .mode_tx(mode_tx),
        .crc(crc8), .tx_bit(tx8), .busy(busy8), .done(done8),
        .crc_ok(ok8), .crc_err(err8), .bit_count(bc8)
    );

    crc_engine #(.W(15), .POLY(15'h4599), .INIT_VAL(15'h0000)) d15 (
        .clk(clk), .rst(rst), .init(init), .enable(enable), .bit_in(bit_in),
        .stuff_bit(stuff_bit), .finish(finish), .mode_tx(mode_tx),
        .crc(crc15), .tx_bit(tx15), .busy(busy15), .done(done15),
        .crc_ok(ok15), .crc_err(err15), .bit_count(bc15)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic b, input logic s);
        enable = 1'b1; bit_in = b; stuff_bit = s;
        step();
        enable = 1'b0; stuff_bit = 1'b0;
    endtask

    task automatic feed_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) feed(v[i], 1'b0);
    endtask

    task automatic do_init();
        init = 1'b1; step(); init = 1'b0;
    endtask

    task automatic do_finish();
        finish = 1'b1; step(); finish = 1'b0;
    endtask

    initial begin
        logic [7:0] a2;
        logic [7:0] exp_tx;
        a2 = 8'hA2;
        exp_tx = 8'h67;

        // Reset state
        step(); step();
        chk("rst_crc", crc8, 8'h00);
        chk("rst_bc", bc8, 16'd0);
        chk("rst_flags", {tx8, busy8, done8, ok8, err8}, 5'b0);
        rst = 1'b0;
        step();

        // IDLE ignores enable and finish
        feed(1'b1, 1'b0);
        do_finish();
        chk("idle_crc", crc8, 8'h00);
        chk("idle_busy", busy8, 1'b0);

        // Plain data: 8'hA2 -> 8'h67, first bit latency
        do_init();
        chk("init_busy", busy8, 1'b1);
        feed(1'b1, 1'b0);
        chk("first_bit", crc8, 8'h07);
        for (int i = 6; i >= 0; i--) feed(a2[i], 1'b0);
        chk("a2_crc", crc8, 8'h67);
        chk("a2_bc", bc8, 16'd8);

        // Stuff bits and stuff without enable are skipped
        do_init();
        chk("reinit_crc", crc8, 8'h00);
        feed(1'b1, 1'b0); feed(1'b1, 1'b1);
        feed(1'b0, 1'b0); feed(1'b1, 1'b0); feed(1'b0, 1'b1);
        stuff_bit = 1'b1; step(); stuff_bit = 1'b0;
        feed(1'b0, 1'b0); feed(1'b0, 1'b0); feed(1'b0, 1'b0);
        feed(1'b1, 1'b1);
        feed(1'b1, 1'b0); feed(1'b0, 1'b0);
        chk("stuff_crc", crc8, 8'h67);
        chk("stuff_bc", bc8, 16'd8);

        // Check mode, good field
        mode_tx = 1'b0;
        do_init();
        feed_byte(8'hA2);
        do_finish();
        chk("chk_busy", {busy8, done8}, 2'b10);
        for (int i = 7; i >= 1; i--) feed(exp_tx[i], 1'b0);
        chk("chk_7bits", {busy8, done8}, 2'b10);
        chk("chk_hold_crc", crc8, 8'h67);
        feed(exp_tx[0], 1'b0);
        chk("chk_ok", {busy8, done8, ok8, err8}, 4'b0110);
        feed(1'b0, 1'b0);
        do_finish();
        chk("done_hold", {crc8, done8, ok8, err8}, {8'h67, 3'b110});

        // Check mode, bad field 8'h66
        do_init();
        feed_byte(8'hA2);
        do_finish();
        feed_byte(8'h66);
        chk("chk_err", {done8, ok8, err8}, 3'b101);
        chk("err_bc", bc8, 16'd8);

        // finish together with the last data bit absorbs it first
        do_init();
        for (int i = 7; i >= 1; i--) feed(a2[i], 1'b0);
        finish = 1'b1; feed(a2[0], 1'b0); finish = 1'b0;
        chk("fin_bit_crc", crc8, 8'h67);
        chk("fin_bit_bc", bc8, 16'd8);
        feed_byte(8'h67);
        chk("fin_bit_ok", {done8, ok8, err8}, 3'b110);

        // Asynchronous reset mid-CHECK
        do_init();
        feed_byte(8'hA2);
        do_finish();
        feed(1'b0, 1'b0); feed(1'b1, 1'b0); feed(1'b1, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("arst_crc", crc8, 8'h00);
        chk("arst_flags", {busy8, done8, ok8, err8, tx8}, 5'b0);
        chk("arst_bc", bc8, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // init with finish: init wins, lands in CALC
        do_init();
        feed(1'b1, 1'b0); feed(1'b0, 1'b0);
        init = 1'b1; finish = 1'b1; step(); init = 1'b0; finish = 1'b0;
        chk("initfin_bc", bc8, 16'd0);
        chk("initfin_st", {busy8, done8}, 2'b10);
        feed(1'b1, 1'b0);
        chk("initfin_calc", crc8, 8'h07);

        // CAN-15 over "123456789"
        do_init();
        for (int k = 1; k <= 9; k++) feed_byte(8'h30 + 8'(k));
        chk("can15_crc", crc15, 15'h059E);
        chk("can15_bc", bc15, 16'd72);

        // Transmit mode
        mode_tx = 1'b1;
        do_init();
        feed_byte(8'hA2);
        do_finish();
`ifdef CRC_TX_SEND_EN
        for (int i = 7; i >= 0; i--) begin
            chk("tx_bit", tx8, exp_tx[i]);
            feed(1'b0, 1'b0);
        end
        chk("tx_ok", {done8, ok8, err8}, 3'b110);
`else
        chk("tx_tied", tx8, 1'b0);
        feed_byte(8'h67);
        chk("tx_off_ok", {done8, ok8, err8, tx8}, 4'b1100);
`endif
        mode_tx = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
